// File: rtl/float_add_sequencer.sv
// Request FIFO plus issue/collect sequencer for the FloatAdder handshake:
// one operation in flight at a time, responses in request order, timeout error path.
module float_add_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int GUARD   = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqOp1,
    input  logic [31:0] ReqOp2,
    input  logic        ReqSub,
    output logic [31:0] AddOp1,
    output logic [31:0] AddOp2,
    output logic        AddInputValid,
    input  logic [31:0] AddResult,
    input  logic        AddResultValid,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespResult,
    output logic        RespError,
    output logic        Busy
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sub;
    } reqEntry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t           state;
    reqEntry_t        fifoMem [DEPTH];
    reqEntry_t        head;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] timer;
    logic             push;
    logic             pop;
    logic             guardOver;
    logic             timedOut;

    assign ReqReady  = (count < CNT_W'(DEPTH));
    assign push      = ReqValid & ReqReady;
    assign pop       = (state == ISSUE);
    assign head      = fifoMem[rdPtr];
    assign guardOver = (timer >= TMR_W'(GUARD));
    assign timedOut  = (timer == TMR_W'(TIMEOUT - 1));
    assign Busy      = (count != '0) | (state != IDLE);

    // NOTE: storage carries no reset; an entry is never read before the count says it was written.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifoMem[wrPtr] <= '{op1: ReqOp1, op2: ReqOp2, sub: ReqSub};
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every output is a register; AddInputValid defaults low each cycle so it can only pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            AddOp1        <= '0;
            AddOp2        <= '0;
            AddInputValid <= 1'b0;
            RespValid     <= 1'b0;
            RespResult    <= '0;
            RespError     <= 1'b0;
            timer         <= '0;
        end else begin
            AddInputValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) state <= ISSUE;
                end
                ISSUE: begin
                    AddOp1        <= head.op1;
                    AddOp2        <= {head.op2[31] ^ head.sub, head.op2[30:0]};
                    AddInputValid <= 1'b1;
                    timer         <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // A real result outranks a timeout landing on the same cycle.
                    if (guardOver && AddResultValid) begin
                        RespResult <= AddResult;
                        RespError  <= 1'b0;
                        RespValid  <= 1'b1;
                        state      <= HOLD;
                    end else if (timedOut) begin
                        RespResult <= '0;
                        RespError  <= 1'b1;
                        RespValid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        RespError <= 1'b0;
                        state     <= (count != '0) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_add_sequencer.sv
// Directed bench for float_add_sequencer: vector table through a behavioural adder,
// plus hand sequences for stale ResultValid, back-pressure and reset mid-operation.
module tb_float_add_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int GUARD   = 1;
    localparam int NEVER   = 1000000;

    logic        Clock;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] ReqOp1;
    logic [31:0] ReqOp2;
    logic        ReqSub;
    logic [31:0] AddOp1;
    logic [31:0] AddOp2;
    logic        AddInputValid;
    logic [31:0] AddResult;
    logic        AddResultValid;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespResult;
    logic        RespError;
    logic        Busy;

    float_add_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp1(ReqOp1), .ReqOp2(ReqOp2), .ReqSub(ReqSub),
        .AddOp1(AddOp1), .AddOp2(AddOp2), .AddInputValid(AddInputValid),
        .AddResult(AddResult), .AddResultValid(AddResultValid),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespResult(RespResult), .RespError(RespError), .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int nApplied    = 0;
    int nMiscompare = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // Behavioural adder: result appears modelLat edges after the edge that raised InputValid.
    int          modelLat    = NEVER;
    logic [31:0] modelResult = '0;
    bit          modelSticky = 1'b0;
    bit          modelTag    = 1'b0;
    bit          modelForce  = 1'b0;

    initial begin
        bit          pend;
        int          k;
        logic [31:0] tagVal;
        pend           = 1'b0;
        k              = 0;
        tagVal         = '0;
        AddResult      = '0;
        AddResultValid = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (!Reset) pend = 1'b0;
            if (AddInputValid) begin
                k      = 0;
                pend   = 1'b1;
                tagVal = AddOp1 ^ AddOp2;
                if (!modelSticky) AddResultValid = 1'b0;
            end else if (pend) begin
                k++;
            end
            if (pend && k == modelLat) begin
                AddResult      = modelTag ? tagVal : modelResult;
                AddResultValid = 1'b1;
                pend           = 1'b0;
            end
            if (modelForce) begin
                AddResult      = 32'h1234_5678;
                AddResultValid = 1'b1;
            end
        end
    end

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sub;
        logic [31:0] modelRes;
        int          lat;
        logic [31:0] expOp2;
        logic [31:0] expRes;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs [9];

    task automatic pushOne(input logic [31:0] op1, input logic [31:0] op2, input logic sub);
        ReqValid = 1'b1;
        ReqOp1   = op1;
        ReqOp2   = op2;
        ReqSub   = sub;
        checkBit("push_ready", ReqReady, 1'b1);
        tick();
        ReqValid = 1'b0;
    endtask

    task automatic waitIssue(output int n);
        n = 0;
        while (!AddInputValid && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic waitResp(input int start, input int bound, output int m);
        m = start;
        while (!RespValid && m < bound) begin
            tick();
            m++;
        end
    endtask

    initial begin
        int          n;
        int          m;
        bit          ok;
        logic [31:0] held;
        logic [31:0] bpOp1 [5];
        logic [31:0] bpOp2 [5];
        logic        bpSub [5];
        logic [31:0] bpExp [5];

        //            op1           op2           sub   model         lat    expOp2        expRes        err   expLat
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3,     32'h40000000, 32'h40400000, 1'b0, 4};
        vecs[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3,     32'hBF800000, 32'h40000000, 1'b0, 4};
        vecs[2] = '{32'h3F800000, 32'hC0000000, 1'b1, 32'h40400000, 1,     32'h40000000, 32'h40400000, 1'b0, 2};
        vecs[3] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 0,     32'h3F800000, 32'h7FC00000, 1'b0, 2};
        vecs[4] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5,     32'hFF800000, 32'h7FC00000, 1'b0, 6};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 2,     32'h80000000, 32'h00000000, 1'b0, 3};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'hDEADBEEF, NEVER, 32'h3F800000, 32'h00000000, 1'b1, 64};
        vecs[7] = '{32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 63,    32'h40A00000, 32'h41200000, 1'b0, 64};
        vecs[8] = '{32'h40800000, 32'h40800000, 1'b1, 32'h00000000, 62,    32'hC0800000, 32'h00000000, 1'b0, 63};

        Reset     = 1'b1;
        ReqValid  = 1'b0;
        ReqOp1    = '0;
        ReqOp2    = '0;
        ReqSub    = 1'b0;
        RespReady = 1'b1;
        #1 Reset = 1'b0;
        #2;
        check("rst_add_op1", AddOp1, 32'h0);
        check("rst_add_op2", AddOp2, 32'h0);
        check("rst_resp_result", RespResult, 32'h0);
        checkBit("rst_input_valid", AddInputValid, 1'b0);
        checkBit("rst_resp_valid", RespValid, 1'b0);
        checkBit("rst_resp_error", RespError, 1'b0);
        checkBit("rst_busy", Busy, 1'b0);
        checkBit("rst_req_ready", ReqReady, 1'b1);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            modelResult = vecs[i].modelRes;
            modelLat    = vecs[i].lat;
            modelSticky = 1'b0;
            modelTag    = 1'b0;
            pushOne(vecs[i].op1, vecs[i].op2, vecs[i].sub);
            waitIssue(n);
            check($sformatf("v%0d_issue_latency", i), 32'(n), 32'd2);
            check($sformatf("v%0d_add_op1", i), AddOp1, vecs[i].op1);
            check($sformatf("v%0d_add_op2", i), AddOp2, vecs[i].expOp2);
            tick();
            checkBit($sformatf("v%0d_issue_pulse", i), AddInputValid, 1'b0);
            waitResp(1, 200, m);
            check($sformatf("v%0d_resp_latency", i), 32'(m), 32'(vecs[i].expLat));
            check($sformatf("v%0d_resp_result", i), RespResult, vecs[i].expRes);
            checkBit($sformatf("v%0d_resp_error", i), RespError, vecs[i].expErr);
            tick();
            checkBit($sformatf("v%0d_accepted", i), RespValid, 1'b0);
            checkBit($sformatf("v%0d_idle", i), Busy, 1'b0);
        end

        // Adder keeps ResultValid high between ops; the guard cycle must skip the old value.
        modelSticky = 1'b1;
        modelTag    = 1'b0;
        modelLat    = 1;
        modelResult = 32'h11111111;
        pushOne(32'h3F800000, 32'h3F800000, 1'b0);
        waitIssue(n);
        waitResp(0, 20, m);
        check("stale_first_result", RespResult, 32'h11111111);
        tick();
        modelResult = 32'h22222222;
        pushOne(32'h40000000, 32'h40000000, 1'b0);
        waitIssue(n);
        checkBit("stale_rv_high_at_issue", AddResultValid, 1'b1);
        waitResp(0, 20, m);
        check("stale_resp_latency", 32'(m), 32'd2);
        check("stale_captured", RespResult, 32'h22222222);
        tick();
        modelSticky = 1'b0;

        // Back-pressure: five requests while the consumer stalls.
        modelTag  = 1'b1;
        modelLat  = 2;
        RespReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bpOp1[i] = 32'h3F800000 + 32'(i);
            bpOp2[i] = 32'h40000000 + 32'(i * 16);
            bpSub[i] = i[0];
            bpExp[i] = bpOp1[i] ^ {bpOp2[i][31] ^ bpSub[i], bpOp2[i][30:0]};
        end
        for (int i = 0; i < 5; i++) begin
            ReqValid = 1'b1;
            ReqOp1   = bpOp1[i];
            ReqOp2   = bpOp2[i];
            ReqSub   = bpSub[i];
            checkBit($sformatf("bp_ready_%0d", i), ReqReady, 1'b1);
            tick();
        end
        ReqOp1 = 32'hFFFFFFFF;
        ReqOp2 = 32'hFFFFFFFF;
        checkBit("bp_full_not_ready", ReqReady, 1'b0);
        checkBit("bp_busy", Busy, 1'b1);
        waitResp(0, 20, m);
        checkBit("bp_first_resp", RespValid, 1'b1);
        held = RespResult;
        ok   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (RespValid !== 1'b1 || RespResult !== held || RespError !== 1'b0 || ReqReady !== 1'b0) ok = 1'b0;
        end
        checkBit("bp_hold_stable", ok, 1'b1);
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitResp(0, 20, m);
            check($sformatf("bp_result_%0d", i), RespResult, bpExp[i]);
            checkBit($sformatf("bp_error_%0d", i), RespError, 1'b0);
            tick();
            if (i < 4) begin
                tick();
                checkBit($sformatf("bp_no_bubble_%0d", i), AddInputValid, 1'b1);
            end
        end
        checkBit("bp_drained", Busy, 1'b0);
        modelTag = 1'b0;

        // Reset on the third WAIT cycle discards the op; a later ResultValid is ignored.
        modelLat = NEVER;
        pushOne(32'h3F800000, 32'h40000000, 1'b0);
        waitIssue(n);
        tick();
        tick();
        #1 Reset = 1'b0;
        #1;
        check("rmid_add_op1", AddOp1, 32'h0);
        check("rmid_add_op2", AddOp2, 32'h0);
        checkBit("rmid_input_valid", AddInputValid, 1'b0);
        checkBit("rmid_resp_valid", RespValid, 1'b0);
        checkBit("rmid_resp_error", RespError, 1'b0);
        check("rmid_resp_result", RespResult, 32'h0);
        checkBit("rmid_busy", Busy, 1'b0);
        tick();
        Reset      = 1'b1;
        modelForce = 1'b1;
        ok         = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (RespValid !== 1'b0 || AddInputValid !== 1'b0 || Busy !== 1'b0) ok = 1'b0;
        end
        checkBit("rmid_no_response", ok, 1'b1);
        modelForce = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/float_add_sequencer.md
Name: float_add_sequencer

Overview:
- Initiator/collector for the FloatAdder operand/result handshake.
- Buffers operand requests from a ready/valid producer in a small FIFO.
- Issues each request to the adder as a one-cycle InputValid pulse, waits for ResultValid, and returns the result to a ready/valid consumer.
- Provides subtract (Op2 sign flip), in-order single outstanding operation, and a timeout error path.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, at least 2).
- TIMEOUT, 64, cycles in WAIT before an error response (at least 4).
- GUARD, 1, cycles after issue during which AddResultValid is ignored (at least 1).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request offered.
- ReqReady  out  1  FIFO can accept; high when count < DEPTH.
- ReqOp1  in  32  float {sign, exponent[7:0], mantissa[22:0]}.
- ReqOp2  in  32  float.
- ReqSub  in  1  1 = compute Op1 - Op2.
- AddOp1  out  32  operand 1 to adder.
- AddOp2  out  32  operand 2 to adder; sign inverted when the entry's Sub = 1.
- AddInputValid  out  1  one-cycle issue pulse.
- AddResult  in  32  adder result.
- AddResultValid  in  1  adder done; level, may stay high.
- RespValid  out  1  response held.
- RespReady  in  1  consumer accepts.
- RespResult  out  32  captured result; 0 on error.
- RespError  out  1  timeout occurred.
- Busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (Reset = 0, async) clears:
  - FIFO pointers and count; FSM goes to IDLE.
  - AddOp1, AddOp2, RespResult = 0.
  - AddInputValid, RespValid, RespError = 0.
  - Timer = 0.
  - Reset mid-operation discards all entries and any pending result. A later AddResultValid is ignored until a new issue.
- FIFO:
  - Push when ReqValid & ReqReady. Entry is {Op1, Op2, Sub}, 65 bits.
  - Pop only on an ISSUE transition.
  - Push and pop in the same cycle on a full FIFO: not allowed, because ReqReady is low when full.
  - Push and pop in the same cycle when partially full: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, go to ISSUE next cycle.
  - ISSUE (1 cycle):
    - AddOp1/AddOp2 are registered from the FIFO head, with Sub applied as AddOp2[31] = Op2[31] ^ Sub.
    - AddInputValid = 1 for exactly this cycle; pop the head; clear the timer; go to WAIT.
    - AddOp1/AddOp2 hold their value after ISSUE until the next ISSUE. The adder latches only on InputValid, but holding keeps waveforms stable.
  - WAIT:
    - The timer increments every cycle.
    - While timer < GUARD, AddResultValid is ignored. This covers the adder's registered ResultValid, which is still stale from the previous operation.
    - If timer >= GUARD and AddResultValid = 1: RespResult <= AddResult, RespError <= 0, RespValid <= 1, go to HOLD.
    - Else if timer == TIMEOUT - 1: RespResult <= 0, RespError <= 1, RespValid <= 1, go to HOLD.
    - A valid result and the timeout in the same cycle: the result wins, RespError = 0.
  - HOLD:
    - RespValid, RespResult and RespError are stable until RespValid & RespReady.
    - On acceptance: RespValid <= 0 and RespError <= 0.
      - If the FIFO is non-empty, go to ISSUE; else go to IDLE. No idle bubble.
- Ordering and latency:
  - Exactly one outstanding adder operation; responses are strictly in request order.
  - Latency from push into an empty FIFO with the FSM in IDLE: AddInputValid 2 cycles after the push edge.
  - RespValid rises 1 cycle after the first qualifying AddResultValid sample.
- Arithmetic: no floating-point computation inside the block beyond the sign flip. NaN/Inf/zero pass through unmodified.
- Busy = (count != 0) | (state != IDLE).

Test Plan:
- Reset mid-WAIT (push 1 request; assert Reset low on the 3rd WAIT cycle) -> all outputs 0, FSM IDLE, Busy = 0. A following AddResultValid = 1 produces no response.
- Single add (Op1 = 0x3F800000, Op2 = 0x40000000, Sub = 0; model returns 0x40400000 with ResultValid 3 cycles after issue; RespReady = 1) -> one AddInputValid pulse with AddOp2 = 0x40000000; RespResult = 0x40400000, RespError = 0, accepted in one cycle.
- Subtract (Op1 = 0x40400000, Op2 = 0x3F800000, Sub = 1) -> AddOp2 = 0xBF800000; the model's 0x40000000 is returned.
- Back-pressure with full FIFO (DEPTH = 4; push 5 with RespReady = 0) -> ReqReady low after 4 accepted while the first is in flight. Then hold RespReady = 0 for 10 cycles: the response stays stable. Release: 5 responses return in order, with ISSUE immediately following each acceptance.
- Stale ResultValid (model holds AddResultValid = 1 continuously from the previous op) -> the value during the GUARD cycle is not captured; the first sample at timer >= GUARD is captured.
- Timeout (model never asserts AddResultValid, TIMEOUT = 64) -> RespValid rises 64 cycles after ISSUE with RespResult = 0 and RespError = 1. A result and the timeout in the same cycle -> RespError = 0 and the result is captured.
